branch_resolve_unit: RTL and testbench

- Parametrised successor to the single-cycle branch controller, for the pipelined core.
- Fetch side: direct-mapped branch target buffer (BTB) with saturating direction counters gives `pred_taken` / `pred_target` combinationally.
- Execute side: resolves the actual outcome with the existing 4-mode encoding, updates the BTB and raises a registered redirect on misprediction.

---
 rtl/branch_resolve_unit_pkg.sv | 25 ++
 rtl/branch_resolve_unit_btb.sv | 80 ++++++++
 rtl/branch_resolve_unit.sv | 124 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and counter helpers for the branch predictor / resolver.
package branch_pkg;

  typedef enum logic [1:0] {
    BRA_DISABLE = 2'd0,
    BRA_JMP     = 2'd1,
    BRA_CMP     = 2'd2,
    BRA_ALU     = 2'd3
  } bra_mode_t;

  typedef enum logic {
    BTB_COND   = 1'b0,
    BTB_UNCOND = 1'b1
  } btb_kind_t;

  // Reset leaves counters weakly not-taken; a fresh allocation starts weakly taken.
  function automatic int unsigned cnt_init_val(input int unsigned cnt_bits);
    return (32'd1 << (cnt_bits - 1)) - 32'd1;
  endfunction

  function automatic int unsigned cnt_weak_taken(input int unsigned cnt_bits);
    return 32'd1 << (cnt_bits - 1);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_btb.sv
// Direct-mapped BTB: combinational lookup port, single update port with saturating counters.
module branch_target_buffer
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int CNT_BITS    = 2,
  parameter int TAG_BITS    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en_i,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            rd_taken_o,
  output logic [XLEN-1:0] rd_target_o,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic            wr_taken_i,
  input  btb_kind_t       wr_kind_i,
  input  logic [XLEN-1:0] wr_target_i
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_RST   = CNT_BITS'(cnt_init_val(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_ALLOC = CNT_BITS'(cnt_weak_taken(CNT_BITS));

  function automatic logic [CNT_BITS-1:0] cnt_step(input logic [CNT_BITS-1:0] c,
                                                   input logic up);
    if (up) return (&c) ? c : c + CNT_BITS'(1);
    else    return (|c) ? c - CNT_BITS'(1) : c;
  endfunction

  logic                valid_q [BTB_ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [BTB_ENTRIES];
  btb_kind_t           kind_q  [BTB_ENTRIES];
  logic [XLEN-1:0]     tgt_q   [BTB_ENTRIES];
  logic [CNT_BITS-1:0] cnt_q   [BTB_ENTRIES];

  logic [IDX_W-1:0]    rd_idx, wr_idx;
  logic [TAG_BITS-1:0] rd_tag, wr_tag;
  logic                rd_hit, wr_hit;

  assign rd_idx = IDX_W'(rd_pc_i >> 2);
  assign rd_tag = TAG_BITS'(rd_pc_i >> (IDX_W + 2));
  assign wr_idx = IDX_W'(wr_pc_i >> 2);
  assign wr_tag = TAG_BITS'(wr_pc_i >> (IDX_W + 2));

  // Lookups see pre-update contents; no bypass from the write port.
  assign rd_hit      = rd_en_i & ~rst & valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag);
  assign rd_taken_o  = rd_hit & ((kind_q[rd_idx] == BTB_UNCOND) | cnt_q[rd_idx][CNT_BITS-1]);
  assign rd_target_o = rd_hit ? tgt_q[rd_idx] : '0;

  assign wr_hit = valid_q[wr_idx] & (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_RST;
      end
    end else if (wr_en_i) begin
      if (wr_hit) begin
        cnt_q[wr_idx] <= cnt_step(cnt_q[wr_idx], wr_taken_i);
      end else if (wr_taken_i) begin
        valid_q[wr_idx] <= 1'b1;
        cnt_q[wr_idx]   <= CNT_ALLOC;
      end
    end
  end

  // Payload is rewritten on every taken resolve, whether hit or fresh allocation.
  always_ff @(posedge clk) begin
    if (wr_en_i && wr_taken_i) begin
      tag_q[wr_idx]  <= wr_tag;
      kind_q[wr_idx] <= wr_kind_i;
      tgt_q[wr_idx]  <= wr_target_i;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: BTB-based fetch prediction, execute-stage resolution and registered redirect.
// Optional statistics counters enabled with `define BRANCH_STATS_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int CNT_BITS    = 2,
  parameter int TAG_BITS    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [1:0]      bra_mode,
  input  logic            cmp_z,
  input  logic            cmp_inv,
  input  logic            alu_z,
  input  logic [XLEN-1:0] src_alu,
  input  logic [XLEN-1:0] src_imm,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_addr
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  bra_mode_t       mode;
  btb_kind_t       wr_kind;
  logic            resolve, taken, mispredict;
  logic [XLEN-1:0] target, fall_through;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_addr_q, redirect_addr_d;

  assign mode         = bra_mode_t'(bra_mode);
  assign resolve      = ex_valid & (mode != BRA_DISABLE);
  assign fall_through = ex_pc + XLEN'(4);
  assign wr_kind      = (mode == BRA_CMP) ? BTB_COND : BTB_UNCOND;

  always_comb begin
    taken  = 1'b0;
    target = ex_pc + src_imm;
    case (mode)
      BRA_JMP: taken = 1'b1;
      BRA_CMP: taken = (cmp_z ? alu_z : src_alu[0]) ^ cmp_inv;
      BRA_ALU: begin
        taken  = 1'b1;
        target = {src_alu[XLEN-1:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

  assign mispredict = resolve & ((taken != ex_pred_taken) |
                                 (taken & (ex_pred_target != target)));

  assign redirect_d      = mispredict;
  assign redirect_addr_d = mispredict ? (taken ? target : fall_through) : redirect_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_q      <= 1'b0;
      redirect_addr_q <= '0;
    end else begin
      redirect_q      <= redirect_d;
      redirect_addr_q <= redirect_addr_d;
    end
  end

  assign redirect      = redirect_q;
  assign redirect_addr = redirect_addr_q;

  branch_target_buffer #(
    .XLEN       (XLEN),
    .BTB_ENTRIES(BTB_ENTRIES),
    .CNT_BITS   (CNT_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (if_valid),
    .rd_pc_i    (if_pc),
    .rd_taken_o (pred_taken),
    .rd_target_o(pred_target),
    .wr_en_i    (resolve),
    .wr_pc_i    (ex_pc),
    .wr_taken_i (taken),
    .wr_kind_i  (wr_kind),
    .wr_target_i(target)
  );

`ifdef BRANCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [31:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;

  assign stat_br_d  = sat_inc(stat_br_q, resolve);
  assign stat_mis_d = sat_inc(stat_mis_q, mispredict);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios then randomized traffic vs a reference model.
module tb_branch_resolve_unit;

  localparam int N    = 64;
  localparam int CB   = 2;
  localparam int CMAX = (1 << CB) - 1;
  localparam int HALF = 1 << (CB - 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  bra_mode;
  logic        cmp_z, cmp_inv, alu_z;
  logic [31:0] src_alu, src_imm;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_addr;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_resolve_unit dut (
    .clk           (clk),
    .rst           (rst),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .bra_mode      (bra_mode),
    .cmp_z         (cmp_z),
    .cmp_inv       (cmp_inv),
    .alu_z         (alu_z),
    .src_alu       (src_alu),
    .src_imm       (src_imm),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .redirect      (redirect),
    .redirect_addr (redirect_addr)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: one record per BTB slot, plain integers.
  bit          m_valid  [N];
  int          m_tag    [N];
  bit          m_uncond [N];
  logic [31:0] m_tgt    [N];
  int          m_cnt    [N];
  bit          exp_redir;
  logic [31:0] exp_addr;
  longint      m_br, m_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc / (4 * N)) % 256);
  endfunction

  task automatic m_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int i;
    i = slot_of(pc);
    t = 1'b0;
    tg = 32'h0;
    if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
      t  = m_uncond[i] || (m_cnt[i] >= HALF);
      tg = m_tgt[i];
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = HALF - 1;
    end
    exp_redir = 1'b0;
    exp_addr  = 32'h0;
    m_br      = 0;
    m_mis     = 0;
  endtask

  // Check outputs for the current cycle, advance the model, then clock once.
  task automatic step();
    bit          et, t, mis;
    logic [31:0] etg, tgt, addr;
    int          i;
    #1;
    if (rst || !if_valid) begin
      et  = 1'b0;
      etg = 32'h0;
    end else begin
      m_lookup(if_pc, et, etg);
    end
    chk("pred_taken", {31'h0, pred_taken}, {31'h0, et});
    chk("pred_target", pred_target, etg);
    chk("redirect", {31'h0, redirect}, {31'h0, exp_redir});
    if (exp_redir) chk("redirect_addr", redirect_addr, exp_addr);
`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches, m_br[31:0]);
    chk("stat_mispredicts", stat_mispredicts, m_mis[31:0]);
`endif
    if (rst) begin
      m_reset();
    end else begin
      exp_redir = 1'b0;
      if (ex_valid && bra_mode != 2'd0) begin
        tgt = ex_pc + src_imm;
        if (bra_mode == 2'd1)      t = 1'b1;
        else if (bra_mode == 2'd2) t = (cmp_z ? alu_z : src_alu[0]) ^ cmp_inv;
        else begin
          t   = 1'b1;
          tgt = src_alu & 32'hFFFF_FFFE;
        end
        addr = t ? tgt : ex_pc + 32'd4;
        mis  = (t != ex_pred_taken) || (t && ex_pred_target != tgt);
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (mis) begin
          if (m_mis < 64'hFFFF_FFFF) m_mis++;
          exp_redir = 1'b1;
          exp_addr  = addr;
        end
        i = slot_of(ex_pc);
        if (m_valid[i] && m_tag[i] == tag_of(ex_pc)) begin
          m_cnt[i] = t ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX)
                       : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
          if (t) begin
            m_tgt[i]    = tgt;
            m_uncond[i] = (bra_mode != 2'd2);
          end
        end else if (t) begin
          m_valid[i]  = 1'b1;
          m_tag[i]    = tag_of(ex_pc);
          m_tgt[i]    = tgt;
          m_uncond[i] = (bra_mode != 2'd2);
          m_cnt[i]    = HALF;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_if(input bit v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
  endtask

  task automatic drive_ex(input bit v, input logic [1:0] mode, input logic [31:0] pc,
                          input bit cz, input bit ci, input bit az,
                          input logic [31:0] alu, input logic [31:0] imm,
                          input bit pt, input logic [31:0] ptg);
    ex_valid       = v;
    bra_mode       = mode;
    ex_pc          = pc;
    cmp_z          = cz;
    cmp_inv        = ci;
    alu_z          = az;
    src_alu        = alu;
    src_imm        = imm;
    ex_pred_taken  = pt;
    ex_pred_target = ptg;
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 5))
      0:       return 32'h100;
      1:       return 32'h104;
      2:       return 32'h200;
      3:       return 32'h344;
      4:       return 32'h1100;
      default: return 32'($urandom_range(0, 16383)) * 32'd4;
    endcase
  endfunction

  initial begin
    bit          rt;
    logic [31:0] rtg, pc;
    rst = 1'b1;
    drive_if(0, 0);
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    m_reset();
    rst = 1'b0;
    #1;
    chk("reset_redirect", {31'h0, redirect}, 32'h0);
    chk("reset_redirect_addr", redirect_addr, 32'h0);

    // Cold lookup, then taken CMP mispredict allocates the entry.
    drive_if(1, 32'h100);
    #1 chk("cold_lookup", {31'h0, pred_taken}, 32'h0);
    drive_ex(1, 2, 32'h100, 1, 0, 1, 0, 32'h40, 0, 0);
    step();
    chk("cmp_redirect", {31'h0, redirect}, 32'h1);
    chk("cmp_redirect_addr", redirect_addr, 32'h140);
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("hit_taken", {31'h0, pred_taken}, 32'h1);
    chk("hit_target", pred_target, 32'h140);
    step();

    // Two not-taken resolves drain the counter.
    drive_ex(1, 2, 32'h100, 1, 0, 0, 0, 32'h40, 1, 32'h140);
    step();
    chk("nt_redirect_addr", redirect_addr, 32'h104);
    drive_ex(1, 2, 32'h100, 1, 0, 0, 0, 32'h40, 0, 0);
    step();
    chk("nt_no_redirect", {31'h0, redirect}, 32'h0);
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("nt_pred", {31'h0, pred_taken}, 32'h0);
    step();

    // ALU jump: bit0 of the computed address is cleared.
    drive_ex(1, 3, 32'h344, 0, 0, 0, 32'h2001, 0, 1, 32'h2000);
    step();
    chk("alu_no_redirect", {31'h0, redirect}, 32'h0);
    drive_ex(1, 3, 32'h348, 0, 0, 0, 32'h2001, 0, 1, 32'h3000);
    step();
    chk("alu_redirect", {31'h0, redirect}, 32'h1);
    chk("alu_redirect_addr", redirect_addr, 32'h2000);

    // Alias 0x100 / 0x200 share a slot; same-cycle lookup sees the old entry.
    drive_if(1, 32'h100);
    drive_ex(1, 1, 32'h200, 0, 0, 0, 0, 32'h10, 0, 0);
    #1 chk("alias_old_target", pred_target, 32'h140);
    step();
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("alias_miss_taken", {31'h0, pred_taken}, 32'h0);
    chk("alias_miss_target", pred_target, 32'h0);
    step();

    // Reset coinciding with / following a mispredict.
    drive_ex(1, 1, 32'h400, 0, 0, 0, 0, 32'h8, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rst_drop_redirect", {31'h0, redirect}, 32'h0);
    drive_ex(1, 1, 32'h400, 0, 0, 0, 0, 32'h8, 0, 0);
    step();
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 chk("rst_cleared_redirect", {31'h0, redirect}, 32'h0);
    drive_if(1, 32'h200);
    #1 chk("rst_lookup_miss", {31'h0, pred_taken}, 32'h0);
    step();

    // Three resolves, two of them mispredicted.
    drive_ex(1, 1, 32'h500, 0, 0, 0, 0, 32'h8, 0, 0);
    step();
    drive_ex(1, 1, 32'h500, 0, 0, 0, 0, 32'h8, 1, 32'h508);
    step();
    drive_ex(1, 2, 32'h600, 1, 0, 0, 0, 32'h20, 1, 32'h620);
    step();
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef BRANCH_STATS_EN
    #1;
    chk("stats_branches_3", stat_branches, 32'd3);
    chk("stats_mispredicts_2", stat_mispredicts, 32'd2);
`endif
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive_if($urandom_range(0, 3) != 0, pick_pc());
      pc = pick_pc();
      drive_ex($urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)), pc,
               1'($urandom), 1'($urandom), 1'($urandom), $urandom,
               ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255)) * 32'd4 : $urandom,
               1'($urandom), $urandom);
      if ($urandom_range(0, 1) != 0) begin
        m_lookup(pc, rt, rtg);
        ex_pred_taken  = rt;
        ex_pred_target = rtg;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
